// File: rtl/tone_seq_gen.sv
// tone_seq_gen: highest-key chromatic square-wave tone generator with octave transpose and sustain
module tone_seq_gen #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_KEYS      = 16,
  parameter int CNT_W       = 22,
  parameter int SUSTAIN_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_KEYS-1:0] keys,
  input  logic [2:0]        oct_shift,
  output logic              beep,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;
  localparam logic [63:0] FMHZ [12] = '{64'd261626, 64'd277183, 64'd293665, 64'd311127,
                                        64'd329628, 64'd349228, 64'd369994, 64'd391995,
                                        64'd415305, 64'd440000, 64'd466164, 64'd493883};
  function automatic logic [63:0] hcalc(input int s);
    return 64'(CLK_HZ) * 64'd1000 / (64'd2 * FMHZ[s]);
  endfunction
  localparam logic [63:0] HT [12] = '{hcalc(0), hcalc(1), hcalc(2), hcalc(3), hcalc(4), hcalc(5),
                                      hcalc(6), hcalc(7), hcalc(8), hcalc(9), hcalc(10), hcalc(11)};
  localparam logic [CNT_W-1:0] MAXV = '1;
  state_t            state, nstate;
  logic [N_KEYS-1:0] ks1, ks;
  logic [5:0]        k;
  logic [3:0]        sidx;
  int                osc, o;
  logic [63:0]       raw;
  logic [CNT_W-1:0]  half, pend, pend_v, cur_half, tone_cnt;
  logic [31:0]       sus_cnt;
  logic              kany, toggle, sus_done;
  always_comb begin
    k = '0;
    for (int i = 0; i < N_KEYS; i++) k = ks[i] ? 6'(i) : k;
    sidx = 4'(k % 6'd12);
    osc = int'($signed(oct_shift));
    osc = osc < -2 ? -2 : osc > 2 ? 2 : osc;
    o = int'(k / 6'd12) + osc;
    o = o < -3 ? -3 : o > 3 ? 3 : o;
    raw = o >= 0 ? HT[sidx] >> o : HT[sidx] << -o;
    half = raw > 64'(MAXV) ? MAXV : raw == 64'd0 ? CNT_W'(1) : raw[CNT_W-1:0];
  end
  always_comb begin
    kany = |ks;
    pend_v = kany ? half : pend;
    toggle = tone_cnt == cur_half - CNT_W'(1);
    sus_done = sus_cnt == 32'(SUSTAIN_CYC - 1);
    nstate = !en ? IDLE :
             state == IDLE ? (kany ? PLAY : IDLE) :
             kany ? PLAY :
             state == PLAY ? (SUSTAIN_CYC > 0 ? SUSTAIN : IDLE) :
             sus_done ? IDLE : SUSTAIN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ks1 <= '0;
      ks <= '0;
      state <= IDLE;
      busy <= 1'b0;
      beep <= 1'b0;
      tone_cnt <= '0;
      sus_cnt <= '0;
      cur_half <= '0;
      pend <= '0;
    end else begin
      ks1 <= keys;
      ks <= ks1;
      state <= nstate;
      busy <= nstate != IDLE;
      pend <= pend_v;
      if (nstate == IDLE) begin
        beep <= 1'b0;
        tone_cnt <= '0;
        sus_cnt <= '0;
      end else if (state == IDLE) begin
        cur_half <= half;
        tone_cnt <= '0;
        sus_cnt <= '0;
        beep <= 1'b1;
      end else begin
        tone_cnt <= toggle ? '0 : tone_cnt + CNT_W'(1);
        sus_cnt <= state == PLAY ? '0 : sus_cnt + 32'd1;
        if (toggle) beep <= ~beep;
        // new pitch only takes effect at the start of a high phase
        if (toggle && !beep) cur_half <= pend_v;
      end
    end
  end
endmodule

// File: doc/tone_seq_gen.md
TONE_SEQ_GEN -- requirements
Module: tone_seq_gen

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter N_KEYS, default 16, range 1..36, meaning the number of chromatic key inputs.
REQ-003 The block SHALL have parameter CNT_W, default 22, meaning the width of the half-period and tone counters.
REQ-004 The block SHALL have parameter SUSTAIN_CYC, default 5_000_000, meaning the tone hold time in clk cycles after release; 0 disables sustain.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port en, input, 1 bit: global enable; low mutes and idles the block.
REQ-008 The block SHALL have port keys, input, N_KEYS bits: asynchronous key levels; bit k is semitone k above C4.
REQ-009 The block SHALL have port oct_shift, input, 3 bits, two's complement: octave transpose, clamped to -2..+2.
REQ-010 The block SHALL have port beep, output, 1 bit: square-wave buzzer drive, 1 = high.
REQ-011 The block SHALL have port busy, output, 1 bit: high in PLAY or SUSTAIN.

Function
REQ-012 keys SHALL pass through a 2-flop synchroniser (ks); all decisions SHALL use ks only.
REQ-013 The selected key SHALL be the highest set index of ks; lower keys SHALL be ignored.
REQ-014 For selected key k: s = k mod 12, o = k/12 + clamp(oct_shift); o SHALL be clamped to -3..+3.
REQ-015 The base half-period table SHALL be H[s] = floor(CLK_HZ*1000 / (2*F[s])), F in mHz: 261626, 277183, 293665, 311127, 329628, 349228, 369994, 391995, 415305, 440000, 466164, 493883.
REQ-016 half = H[s]>>o for o>=0 and H[s]<<(-o) for o<0; a result exceeding 2^CNT_W-1 SHALL saturate to 2^CNT_W-1; a result of 0 SHALL be forced to 1.
REQ-017 The FSM SHALL have three states: IDLE, PLAY and SUSTAIN.
REQ-018 IDLE -> PLAY when ks!=0: cur_half<=half, tone_cnt<=0, beep<=1 on the same edge, so beep rises on the 3rd edge that samples the key high.
REQ-019 In PLAY/SUSTAIN, tone_cnt SHALL increment each cycle; when tone_cnt==cur_half-1: tone_cnt<=0, beep<=~beep.
REQ-020 A pending half-period SHALL be recomputed every cycle from ks and oct_shift while ks!=0 and held while ks==0.
REQ-021 cur_half SHALL load the pending value only on a 0->1 toggle of beep (period boundary); key or octave changes SHALL never cause a partial half-period.
REQ-022 PLAY -> SUSTAIN when ks==0 and SUSTAIN_CYC>0, with sus_cnt<=0; when SUSTAIN_CYC==0, PLAY -> IDLE directly.
REQ-023 In SUSTAIN, tone generation SHALL continue at cur_half and sus_cnt SHALL increment each cycle.
REQ-024 When sus_cnt==SUSTAIN_CYC-1, the FSM SHALL go to IDLE with beep<=0 and tone_cnt<=0, regardless of phase.
REQ-025 SUSTAIN -> PLAY when ks!=0, with no counter restart; the new pitch SHALL apply at the next boundary (REQ-021).
REQ-026 In IDLE, beep=0 and busy=0; busy SHALL be registered and asserted in the same cycle as the state.
REQ-027 en==0 SHALL force IDLE, beep<=0 and all counters <=0 on that edge, taking priority over all transitions; the synchroniser keeps running.

Reset
REQ-028 rst_n==0 at an edge SHALL force IDLE, beep=0, busy=0, tone_cnt=0, sus_cnt=0, cur_half=0 and synchroniser flops =0, with priority over en.
REQ-029 Reset asserted mid-tone SHALL take effect on that edge; after release, the block SHALL restart from IDLE per REQ-018.

Verification
REQ-030 Defaults, en=1, keys=0x0001, oct_shift=0 -> beep rises on the 3rd edge, high 95556 cycles, low 95556 cycles, busy=1.
REQ-031 keys=0x0201 -> key 9 wins, half=56818; oct_shift=-1 -> 113636, applied only at the next 0->1 boundary.
REQ-032 N_KEYS=24, key 12 held, oct_shift=+2 -> o=3, half=95556>>3=11944; oct_shift=-2 with key 0 -> 382224.
REQ-033 SUSTAIN_CYC=1000, key released mid-period -> tone continues; IDLE and beep=0 exactly 1000 cycles after SUSTAIN entry; re-press at cycle 500 -> stays busy, no phase glitch.
REQ-034 en dropped mid-period -> beep=0 and busy=0 next edge; rst_n=0 while en=0 and keys set -> all outputs 0; release -> tone restarts per REQ-018.
REQ-035 Key toggled for a single clk cycle -> a tone of at least one full period (PLAY, then SUSTAIN), never a runt pulse.
